// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot/run/halt/error control with branch, jump and
// register-jump redirection plus a saturating count of PC advances.
module pc_sequencer #(
  parameter logic [31:0] PC_START = 32'h00400020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        halt,
  input  logic        restart,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] instr_count
);

  localparam int unsigned AW = 32;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_cnt;
  logic          r_pc_valid;
  logic          r_halted;
  logic          r_misalign_err;

  logic [AW-1:0] w_pc_plus4;
  logic [AW-1:0] w_br_target;
  logic [AW-1:0] w_jmp_target;
  logic [AW-1:0] w_cnt_next;
  logic          w_jr_misaligned;

  // Candidate next addresses; all arithmetic wraps modulo 2^32.
  assign w_pc_plus4      = r_pc + AW'(4);
  assign w_br_target     = w_pc_plus4 + (br_offset << 2);
  assign w_jmp_target    = {w_pc_plus4[31:28], jmp_index, 2'b00};
  assign w_cnt_next      = (&r_cnt) ? r_cnt : r_cnt + AW'(1);
  assign w_jr_misaligned = |jr_target[1:0];

  // Status flags are registered alongside the state so they always match it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_BOOT;
      r_pc           <= PC_START;
      r_cnt          <= '0;
      r_pc_valid     <= 1'b0;
      r_halted       <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state    <= S_RUN;
          r_pc_valid <= 1'b1;
        end
        S_RUN: begin
          if (halt) begin
            r_state    <= S_HALT;
            r_pc_valid <= 1'b0;
            r_halted   <= 1'b1;
          end else if (stall) begin
            r_state <= S_RUN;
          end else if (jr) begin
            if (w_jr_misaligned) begin
              r_state        <= S_ERR;
              r_pc_valid     <= 1'b0;
              r_misalign_err <= 1'b1;
            end else begin
              r_pc  <= jr_target;
              r_cnt <= w_cnt_next;
            end
          end else if (jmp) begin
            r_pc  <= w_jmp_target;
            r_cnt <= w_cnt_next;
          end else if (br_taken) begin
            r_pc  <= w_br_target;
            r_cnt <= w_cnt_next;
          end else begin
            r_pc  <= w_pc_plus4;
            r_cnt <= w_cnt_next;
          end
        end
        S_HALT, S_ERR: begin
          if (restart) begin
            r_state        <= S_BOOT;
            r_pc           <= PC_START;
            r_cnt          <= '0;
            r_pc_valid     <= 1'b0;
            r_halted       <= 1'b0;
            r_misalign_err <= 1'b0;
          end
        end
        default: begin
          r_state        <= S_BOOT;
          r_pc           <= PC_START;
          r_cnt          <= '0;
          r_pc_valid     <= 1'b0;
          r_halted       <= 1'b0;
          r_misalign_err <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = r_pc;
  assign pc_valid     = r_pc_valid;
  assign halted       = r_halted;
  assign misalign_err = r_misalign_err;
  assign instr_count  = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios from the requirement examples plus
// randomized traffic checked against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] START = 32'h00400020;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_ERR  = 3;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        jmp;
  logic [25:0] jmp_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        halt;
  logic        restart;
  logic [31:0] pc;
  logic        pc_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] instr_count;

  int n_checks;
  int n_fail;

  // Behavioural model state
  int          m_st;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  logic [66:0] got;
  logic [66:0] exp;

  pc_sequencer #(.PC_START(START)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_offset(br_offset), .jmp(jmp), .jmp_index(jmp_index), .jr(jr),
    .jr_target(jr_target), .halt(halt), .restart(restart), .pc(pc),
    .pc_valid(pc_valid), .halted(halted), .misalign_err(misalign_err),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [66:0] obs();
    return {pc, instr_count, pc_valid, halted, misalign_err};
  endfunction

  function automatic logic [66:0] want(logic [31:0] p, logic [31:0] c,
                                       logic v, logic h, logic e);
    return {p, c, v, h, e};
  endfunction

  task automatic clr_inputs();
    stall = 0; br_taken = 0; br_offset = '0; jmp = 0; jmp_index = '0;
    jr = 0; jr_target = '0; halt = 0; restart = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Advances the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    logic [31:0] nxt;
    logic        adv;
    adv = 1'b0;
    nxt = m_pc;
    case (m_st)
      M_BOOT: m_st = M_RUN;
      M_RUN: begin
        if (halt) m_st = M_HALT;
        else if (stall) adv = 1'b0;
        else if (jr) begin
          if (jr_target % 4 != 0) m_st = M_ERR;
          else begin nxt = jr_target; adv = 1'b1; end
        end else if (jmp) begin
          nxt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, jmp_index} * 32'd4);
          adv = 1'b1;
        end else if (br_taken) begin
          nxt = m_pc + 32'd4 + br_offset * 32'd4;
          adv = 1'b1;
        end else begin
          nxt = m_pc + 32'd4;
          adv = 1'b1;
        end
      end
      default: begin
        if (restart) begin m_st = M_BOOT; nxt = START; m_cnt = 0; end
      end
    endcase
    m_pc = nxt;
    if (adv && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    got = obs(); exp = want(START, 0, 0, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", got, exp); end
    tick();
    tick();
    got = obs();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_clocked: got %h expected %h", got, exp); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] pcs [4];
    logic [31:0] cnts [4];
    logic        vals [4];
    clr_inputs();
    do_reset();
    pcs  = '{32'h00400020, 32'h00400020, 32'h00400024, 32'h00400028};
    cnts = '{0, 0, 1, 2};
    vals = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      got = obs(); exp = want(pcs[i], cnts[i], vals[i], 0, 0);
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL seq_step%0d: got %h expected %h", i, got, exp); end
    end
    restart = 1'b1;
    tick();
    got = obs(); exp = want(32'h0040002C, 3, 1, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL restart_in_run: got %h expected %h", got, exp); end
    restart = 1'b0;
  endtask

  task automatic test_branch();
    clr_inputs();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    br_taken = 1; br_offset = 32'hFFFFFFFC; stall = 1;
    tick();
    got = obs(); exp = want(32'h00400030, 4, 1, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL branch_stalled: got %h expected %h", got, exp); end
    stall = 0;
    tick();
    got = obs(); exp = want(32'h00400024, 5, 1, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL branch_back: got %h expected %h", got, exp); end
    br_offset = 32'h00000010;
    tick();
    got = obs(); exp = want(32'h00400068, 6, 1, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL branch_fwd: got %h expected %h", got, exp); end
  endtask

  task automatic test_jump();
    clr_inputs();
    do_reset();
    for (int i = 0; i < 9; i++) tick();
    jmp = 1; jmp_index = 26'h0100010; br_taken = 1; br_offset = 32'h00000005;
    tick();
    got = obs(); exp = want(32'h00400040, 9, 1, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL jmp_over_br: got %h expected %h", got, exp); end
    jmp = 0; br_taken = 0; jr = 1; jr_target = 32'hA0000010;
    tick();
    jr = 0; jmp = 1; jmp_index = 26'h3FFFFFF;
    tick();
    got = obs(); exp = want(32'hAFFFFFFC, 11, 1, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL jmp_region: got %h expected %h", got, exp); end
  endtask

  task automatic test_wrap();
    clr_inputs();
    do_reset();
    tick();
    jr = 1; jr_target = 32'hFFFFFFFC;
    tick();
    jr = 0;
    tick();
    got = obs(); exp = want(32'h00000000, 2, 1, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL pc_wrap: got %h expected %h", got, exp); end
    br_taken = 1; br_offset = 32'hFFFFFFFE;
    tick();
    got = obs(); exp = want(32'hFFFFFFFC, 3, 1, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL branch_wrap: got %h expected %h", got, exp); end
  endtask

  task automatic test_jr_err();
    clr_inputs();
    do_reset();
    tick(); tick();
    jr = 1; jr_target = 32'h00400042; jmp = 1;
    tick();
    got = obs(); exp = want(32'h00400024, 1, 0, 0, 1);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL jr_misalign: got %h expected %h", got, exp); end
    jr_target = 32'h00400100; halt = 1;
    tick(); tick();
    got = obs();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL err_hold: got %h expected %h", got, exp); end
    clr_inputs();
    restart = 1;
    tick();
    got = obs(); exp = want(START, 0, 0, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL err_restart: got %h expected %h", got, exp); end
    tick();
    got = obs(); exp = want(START, 0, 1, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL restart_run: got %h expected %h", got, exp); end
    restart = 0;
  endtask

  task automatic test_halt();
    clr_inputs();
    do_reset();
    tick(); tick();
    halt = 1; jr = 1; jr_target = 32'h00001000;
    tick();
    got = obs(); exp = want(32'h00400024, 1, 0, 1, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL halt_enter: got %h expected %h", got, exp); end
    clr_inputs();
    br_taken = 1; br_offset = 32'h00000040;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = obs();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL halt_hold%0d: got %h expected %h", i, got, exp); end
    end
    clr_inputs();
    restart = 1;
    tick();
    got = obs(); exp = want(START, 0, 0, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL halt_restart: got %h expected %h", got, exp); end
    restart = 0;
  endtask

  task automatic test_async_reset();
    clr_inputs();
    do_reset();
    tick(); tick(); tick();
    #2;
    reset = 1;
    #1;
    got = obs(); exp = want(START, 0, 0, 0, 0);
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL async_run: got %h expected %h", got, exp); end
    jmp = 1; jmp_index = 26'h0000100;
    tick();
    got = obs();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_abort: got %h expected %h", got, exp); end
    reset = 0;
    clr_inputs();
    tick();
    jr = 1; jr_target = 32'h00000003;
    tick();
    jr = 0;
    #3;
    reset = 1;
    #1;
    got = obs();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL async_err: got %h expected %h", got, exp); end
    tick();
    reset = 0;
  endtask

  task automatic test_random();
    logic [31:0] t;
    clr_inputs();
    do_reset();
    m_st = M_BOOT; m_pc = START; m_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      halt      = ($urandom_range(0, 19) == 0);
      stall     = ($urandom_range(0, 5) == 0);
      jr        = ($urandom_range(0, 9) == 0);
      t         = $urandom();
      if ($urandom_range(0, 1) == 0) t = t & 32'hFFFF_FFFC;
      jr_target = t;
      jmp       = ($urandom_range(0, 7) == 0);
      jmp_index = 26'($urandom());
      br_taken  = ($urandom_range(0, 3) == 0);
      br_offset = $urandom();
      restart   = ($urandom_range(0, 3) == 0);
      model_step();
      tick();
      got = obs();
      exp = want(m_pc, m_cnt, m_st == M_RUN, m_st == M_HALT, m_st == M_ERR);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, got, exp);
      end
    end
    clr_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap();
    test_jr_err();
    test_halt();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
